// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: sequences core reset, the trig and check strobes for
// the RVFI checker instances, and counts retirements on the RVFI valid bus.
module rvfi_check_sequencer #(
    parameter int NRET         = 1,
    parameter int RESET_CYCLES = 1,
    parameter int TRIG_CYCLE   = 5,
    parameter int CHECK_CYCLE  = 10,
    parameter int CW           = 8,
    parameter int RW           = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NRET-1:0] rvfi_valid,
    output logic            core_reset,
    output logic            trig,
    output logic            check,
    output logic            done,
    output logic [CW-1:0]   cycle,
    output logic [RW-1:0]   retired,
    output logic [RW-1:0]   retired_trig
);

    // Reject inconsistent configurations while elaborating.
    if (RESET_CYCLES < 1) begin : g_err_reset_cycles
        $error("RESET_CYCLES must be >= 1");
    end
    if (TRIG_CYCLE < RESET_CYCLES) begin : g_err_trig_cycle
        $error("TRIG_CYCLE must be >= RESET_CYCLES");
    end
    if (CHECK_CYCLE <= TRIG_CYCLE) begin : g_err_check_cycle
        $error("CHECK_CYCLE must be > TRIG_CYCLE");
    end
    if (CW < 31 && ((1 << CW) - 1) < CHECK_CYCLE) begin : g_err_cw
        $error("CW too narrow to reach CHECK_CYCLE");
    end

    localparam int PW = $clog2(NRET + 1);
    localparam int SW = RW + PW;

    localparam logic [CW-1:0] CYCLE_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] RESET_AT    = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] TRIG_AT     = CW'(TRIG_CYCLE);
    localparam logic [CW-1:0] CHECK_AT    = CW'(CHECK_CYCLE);
    localparam logic [SW-1:0] RETIRED_MAX = {{PW{1'b0}}, {RW{1'b1}}};

    typedef enum logic [2:0] {
        S_RESET,
        S_PRE,
        S_TRIG,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cycle_inc;
    logic [PW-1:0]   valid_count;
    logic [SW-1:0]   retired_sum;
    logic [SW-1:0]   retired_trig_sum;
    logic            trig_window;

    // Saturating increment of the cycle counter; boundaries are compared
    // against this value so the transition lands on the boundary edge.
    always_comb begin
        cycle_inc = (cycle == CYCLE_MAX) ? cycle : cycle + 1'b1;
    end

    // Next-state selection, including the shortcuts for back-to-back phases.
    always_comb begin
        state_next = state;
        case (state)
            S_RESET: if (cycle_inc == RESET_AT)
                         state_next = (TRIG_CYCLE == RESET_CYCLES) ? S_TRIG : S_PRE;
            S_PRE:   if (cycle_inc == TRIG_AT)
                         state_next = S_TRIG;
            S_TRIG:  state_next = (CHECK_CYCLE == TRIG_CYCLE + 1) ? S_CHECK : S_WAIT;
            S_WAIT:  if (cycle_inc == CHECK_AT)
                         state_next = S_CHECK;
            S_CHECK: state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_RESET;
        endcase
    end

    // Popcount of the retirement channels and saturating counter sums.
    always_comb begin
        valid_count = '0;
        for (int i = 0; i < NRET; i++) begin
            valid_count = valid_count + PW'(rvfi_valid[i]);
        end
        retired_sum      = SW'(retired) + SW'(valid_count);
        retired_trig_sum = SW'(retired_trig) + SW'(valid_count);
        if (retired_sum > RETIRED_MAX)
            retired_sum = RETIRED_MAX;
        if (retired_trig_sum > RETIRED_MAX)
            retired_trig_sum = RETIRED_MAX;
        trig_window = (state == S_TRIG) || (state == S_WAIT) ||
                      (state == S_CHECK) || (state == S_DONE);
    end

    // Sequencer FSM with outputs registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_RESET;
            cycle      <= '0;
            core_reset <= 1'b1;
            trig       <= 1'b0;
            check      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            cycle      <= cycle_inc;
            core_reset <= (state_next == S_RESET);
            trig       <= (state_next == S_TRIG);
            check      <= (state_next == S_CHECK);
            done       <= (state_next == S_DONE);
        end
    end

    // Retirement counters: everything out of core reset, and from trig onward.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired      <= '0;
            retired_trig <= '0;
        end else begin
            if (!core_reset)
                retired <= retired_sum[RW-1:0];
            if (trig_window)
                retired_trig <= retired_trig_sum[RW-1:0];
        end
    end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Testbench for rvfi_check_sequencer: table of scenarios over three
// configurations, with a per-cycle scoreboard of expected outputs.
module tb_rvfi_check_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rvfi_valid = 2'b00;

    always #5 clock = ~clock;

    // Configuration A: NRET=2, RESET=2, TRIG=5, CHECK=10, RW=8
    logic       cr_a, tr_a, ck_a, dn_a;
    logic [7:0] cyc_a, ret_a, rtr_a;
    // Configuration B: same timing, RW=3
    logic       cr_b, tr_b, ck_b, dn_b;
    logic [7:0] cyc_b;
    logic [2:0] ret_b, rtr_b;
    // Configuration C: RESET=1, TRIG=1, CHECK=2
    logic       cr_c, tr_c, ck_c, dn_c;
    logic [7:0] cyc_c, ret_c, rtr_c;

    rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(2), .TRIG_CYCLE(5), .CHECK_CYCLE(10),
                           .CW(8), .RW(8)) dut_a (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid),
        .core_reset(cr_a), .trig(tr_a), .check(ck_a), .done(dn_a),
        .cycle(cyc_a), .retired(ret_a), .retired_trig(rtr_a));

    rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(2), .TRIG_CYCLE(5), .CHECK_CYCLE(10),
                           .CW(8), .RW(3)) dut_b (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid),
        .core_reset(cr_b), .trig(tr_b), .check(ck_b), .done(dn_b),
        .cycle(cyc_b), .retired(ret_b), .retired_trig(rtr_b));

    rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(1), .TRIG_CYCLE(1), .CHECK_CYCLE(2),
                           .CW(8), .RW(8)) dut_c (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid),
        .core_reset(cr_c), .trig(tr_c), .check(ck_c), .done(dn_c),
        .cycle(cyc_c), .retired(ret_c), .retired_trig(rtr_c));

    typedef struct {
        logic       cr, tr, ck, dn;
        logic [7:0] cyc, ret, rtr;
    } exp_t;

    typedef struct {
        int         sel;
        logic [1:0] vld;
        int         v_last;
        int         ncyc;
        int         at;
        int         exp_ret;
        int         exp_rtr;
    } scn_t;

    int p_rc[3]   = '{2, 2, 1};
    int p_tc[3]   = '{5, 5, 1};
    int p_cc[3]   = '{10, 10, 2};
    int p_rmax[3] = '{255, 7, 255};

    int   sel = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ar = 0;
    int   at_ = 0;
    exp_t sb[$];
    scn_t tbl[5];

    logic       o_cr, o_tr, o_ck, o_dn;
    logic [7:0] o_cyc, o_ret, o_rtr;

    always_comb begin
        o_cr = cr_a; o_tr = tr_a; o_ck = ck_a; o_dn = dn_a;
        o_cyc = cyc_a; o_ret = ret_a; o_rtr = rtr_a;
        if (sel == 1) begin
            o_cr = cr_b; o_tr = tr_b; o_ck = ck_b; o_dn = dn_b;
            o_cyc = cyc_b; o_ret = {5'b0, ret_b}; o_rtr = {5'b0, rtr_b};
        end else if (sel == 2) begin
            o_cr = cr_c; o_tr = tr_c; o_ck = ck_c; o_dn = dn_c;
            o_cyc = cyc_c; o_ret = ret_c; o_rtr = rtr_c;
        end
    end

    function automatic int sat(int x, int m);
        return (x > m) ? m : x;
    endfunction

    function automatic int popc(logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    // Expected outputs in cycle n from the timeline, using current accumulators.
    function automatic exp_t model(int s, int n);
        exp_t e;
        e.cr  = (n < p_rc[s]);
        e.tr  = (n == p_tc[s]);
        e.ck  = (n == p_cc[s]);
        e.dn  = (n > p_cc[s]);
        e.cyc = 8'(sat(n, 255));
        e.ret = 8'(ar);
        e.rtr = 8'(at_);
        return e;
    endfunction

    task automatic cmp(string name, int tag, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d tag%0d: got %0d, expected %0d", name, sel, tag, act, exp);
        end
    endtask

    task automatic check_pop(int tag);
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", tag, 0, 1);
        end else begin
            e = sb.pop_front();
            cmp("core_reset", tag, int'(o_cr), int'(e.cr));
            cmp("trig", tag, int'(o_tr), int'(e.tr));
            cmp("check", tag, int'(o_ck), int'(e.ck));
            cmp("done", tag, int'(o_dn), int'(e.dn));
            cmp("cycle", tag, int'(o_cyc), int'(e.cyc));
            cmp("retired", tag, int'(o_ret), int'(e.ret));
            cmp("retired_trig", tag, int'(o_rtr), int'(e.rtr));
        end
    endtask

    // Hold reset for two edges and check the reset values; leaves reset low.
    task automatic start(int s);
        sel = s;
        reset = 1'b1;
        rvfi_valid = 2'b00;
        ar = 0;
        at_ = 0;
        repeat (2) @(negedge clock);
        #1;
        sb.push_back(model(s, 0));
        check_pop(-1);
        reset = 1'b0;
    endtask

    // Drive cycle n's valid, advance one cycle, check cycle n+1.
    task automatic step(int s, int n, logic [1:0] v);
        rvfi_valid = v;
        if (n >= p_rc[s]) ar = sat(ar + popc(v), p_rmax[s]);
        if (n >= p_tc[s]) at_ = sat(at_ + popc(v), p_rmax[s]);
        sb.push_back(model(s, n + 1));
        @(negedge clock);
        #1;
        check_pop(n + 1);
    endtask

    initial begin
        tbl[0] = '{0, 2'b00, 99, 14, 11, 0, 0};
        tbl[1] = '{0, 2'b11, 99, 14, 11, 18, 12};
        tbl[2] = '{0, 2'b01, 1, 14, 11, 0, 0};
        tbl[3] = '{1, 2'b11, 9, 14, 12, 7, 7};
        tbl[4] = '{2, 2'b10, 99, 8, 5, 4, 4};

        for (int t = 0; t < 5; t++) begin
            start(tbl[t].sel);
            for (int n = 0; n < tbl[t].ncyc; n++) begin
                if (n == tbl[t].at) begin
                    cmp("tbl_retired", n, int'(o_ret), tbl[t].exp_ret);
                    cmp("tbl_retired_trig", n, int'(o_rtr), tbl[t].exp_rtr);
                end
                step(tbl[t].sel, n, (n <= tbl[t].v_last) ? tbl[t].vld : 2'b00);
            end
        end

        // Reset pulsed in cycle 7 while waiting for check, then a full rerun.
        start(0);
        for (int n = 0; n < 7; n++) step(0, n, 2'b11);
        reset = 1'b1;
        rvfi_valid = 2'b11;
        ar = 0;
        at_ = 0;
        sb.push_back(model(0, 0));
        @(negedge clock);
        #1;
        check_pop(8);
        reset = 1'b0;
        for (int n = 0; n < 13; n++) step(0, n, 2'b11);

        cmp("scoreboard_drained", 0, sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
